// File: rtl/mem_port_arbiter.sv
// Shares one single-ported 32-bit memory between instruction fetch and load/store.
// Optional fetch anti-starvation counter is enabled by defining ARB_STARVE_EN.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_flush,
    output logic        o_if_valid,
    output logic [31:0] o_if_rdata,
    output logic        o_if_busy,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [3:0]  i_d_be,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_ready,
    output logic [31:0] o_d_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t r_state;
    logic   r_kill;
    logic   w_starve_hit;
    logic   w_grant_d;
    logic   w_grant_i;
    logic   w_unused;

    // Memory is word addressed; byte offsets are dropped.
    assign w_unused = ^{i_if_addr[1:0], i_d_addr[1:0]};

`ifdef ARB_STARVE_EN
    logic [3:0] r_starve;

    assign w_starve_hit = (r_starve == 4'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (r_state == IDLE) begin
            if (!i_if_req || w_grant_i)
                r_starve <= '0;
            else if (w_grant_d && !w_starve_hit)
                r_starve <= r_starve + 4'd1;
        end
    end
`else
    // Never true for a legal STARVE_MAX, leaving data with strict priority.
    assign w_starve_hit = (STARVE_MAX == 0);
`endif

    assign w_grant_d = i_d_req && !(i_if_req && w_starve_hit);
    assign w_grant_i = i_if_req && !w_grant_d;
    assign o_if_busy = i_if_req && !o_if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_kill      <= 1'b0;
            o_if_valid  <= 1'b0;
            o_if_rdata  <= '0;
            o_d_ready   <= 1'b0;
            o_d_rdata   <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_if_valid <= 1'b0;
            o_d_ready  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_kill <= 1'b0;
                    if (w_grant_d) begin
                        r_state     <= BUSY_D;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_d_we;
                        o_mem_be    <= i_d_be;
                        o_mem_addr  <= i_d_addr[31:2];
                        o_mem_wdata <= i_d_wdata;
                    end else if (w_grant_i) begin
                        r_state     <= BUSY_I;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= 1'b0;
                        o_mem_be    <= 4'hF;
                        o_mem_addr  <= i_if_addr[31:2];
                        o_mem_wdata <= '0;
                    end
                end
                BUSY_I: begin
                    if (i_mem_ready) begin
                        r_state   <= IDLE;
                        o_mem_req <= 1'b0;
                        r_kill    <= 1'b0;
                        // A flush arriving with the response still makes it stale.
                        if (!r_kill && !i_if_flush) begin
                            o_if_valid <= 1'b1;
                            o_if_rdata <= i_mem_rdata;
                        end
                    end else if (i_if_flush) begin
                        r_kill <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (i_mem_ready) begin
                        r_state   <= IDLE;
                        o_mem_req <= 1'b0;
                        o_d_ready <= 1'b1;
                        if (!o_mem_we)
                            o_d_rdata <= i_mem_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; memory responses are driven by hand.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_valid, if_busy;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ready;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef ARB_STARVE_EN
    localparam int N_DATA = 4;
`else
    localparam int N_DATA = 6;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_valid(if_valid), .o_if_rdata(if_rdata), .o_if_busy(if_busy),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_ready(d_ready), .o_d_rdata(d_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_be(mem_be),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_req"},   32'(mem_req),   32'h0);
        chk({tag, " mem_we"},    32'(mem_we),    32'h0);
        chk({tag, " mem_be"},    32'(mem_be),    32'h0);
        chk({tag, " mem_addr"},  32'(mem_addr),  32'h0);
        chk({tag, " mem_wdata"}, mem_wdata,      32'h0);
        chk({tag, " if_valid"},  32'(if_valid),  32'h0);
        chk({tag, " if_rdata"},  if_rdata,       32'h0);
        chk({tag, " d_ready"},   32'(d_ready),   32'h0);
        chk({tag, " d_rdata"},   d_rdata,        32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;

        #2;
        chk_all_zero("reset");
        chk("reset if_busy", 32'(if_busy), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Single fetch
        if_req = 1; if_addr = 32'h10;
        #1 chk("fetch if_busy", 32'(if_busy), 32'h1);
        step();
        chk("fetch mem_req", 32'(mem_req), 32'h1);
        chk("fetch mem_addr", 32'(mem_addr), 32'h4);
        chk("fetch mem_be", 32'(mem_be), 32'hF);
        chk("fetch mem_we", 32'(mem_we), 32'h0);
        mem_ready = 1; mem_rdata = 32'h00500093;
        step();
        mem_ready = 0;
        chk("fetch if_valid", 32'(if_valid), 32'h1);
        chk("fetch if_rdata", if_rdata, 32'h00500093);
        chk("fetch mem_req drop", 32'(mem_req), 32'h0);
        chk("fetch if_busy off", 32'(if_busy), 32'h0);
        if_req = 0;
        step();
        chk("fetch pulse end", 32'(if_valid), 32'h0);
        chk("fetch idle", 32'(mem_req), 32'h0);

        // Contention: load wins, then fetch
        if_req = 1; if_addr = 32'h20;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h100;
        step();
        chk("cont data first", 32'(mem_addr), 32'h40);
        chk("cont data we", 32'(mem_we), 32'h0);
        mem_ready = 1; mem_rdata = 32'h11112222;
        step();
        mem_ready = 0;
        chk("cont d_ready", 32'(d_ready), 32'h1);
        chk("cont d_rdata", d_rdata, 32'h11112222);
        chk("cont no if_valid", 32'(if_valid), 32'h0);
        d_req = 0;
        step();
        chk("cont fetch grant", 32'(mem_req), 32'h1);
        chk("cont fetch addr", 32'(mem_addr), 32'h8);
        mem_ready = 1; mem_rdata = 32'h22223333;
        step();
        mem_ready = 0;
        chk("cont if_valid", 32'(if_valid), 32'h1);
        chk("cont if_rdata", if_rdata, 32'h22223333);
        if_req = 0;
        step();

        // Store
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        step();
        chk("store mem_we", 32'(mem_we), 32'h1);
        chk("store mem_be", 32'(mem_be), 32'h3);
        chk("store mem_addr", 32'(mem_addr), 32'h80);
        chk("store mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_ready = 0;
        chk("store d_ready", 32'(d_ready), 32'h1);
        chk("store d_rdata kept", d_rdata, 32'h11112222);
        d_req = 0; d_we = 0;
        step();
        chk("store pulse end", 32'(d_ready), 32'h0);

        // Flush before mem_ready, then a new fetch from the redirected PC
        if_req = 1; if_addr = 32'h30;
        step();
        chk("flush1 grant", 32'(mem_addr), 32'hC);
        if_flush = 1;
        step();
        if_flush = 0; if_addr = 32'h40;
        chk("flush1 mem_req held", 32'(mem_req), 32'h1);
        chk("flush1 addr held", 32'(mem_addr), 32'hC);
        mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
        step();
        mem_ready = 0;
        chk("flush1 no if_valid", 32'(if_valid), 32'h0);
        chk("flush1 if_rdata kept", if_rdata, 32'h22223333);
        chk("flush1 mem_req drop", 32'(mem_req), 32'h0);
        step();
        chk("flush1 refetch addr", 32'(mem_addr), 32'h10);
        mem_ready = 1; mem_rdata = 32'h0A0A0A0A;
        step();
        mem_ready = 0;
        chk("flush1 refetch valid", 32'(if_valid), 32'h1);
        chk("flush1 refetch data", if_rdata, 32'h0A0A0A0A);
        if_req = 0;
        step();

        // Flush on the same edge as mem_ready
        if_req = 1; if_addr = 32'h50;
        step();
        chk("flush2 grant", 32'(mem_addr), 32'h14);
        mem_ready = 1; mem_rdata = 32'h77777777; if_flush = 1;
        step();
        mem_ready = 0; if_flush = 0; if_req = 0;
        chk("flush2 no if_valid", 32'(if_valid), 32'h0);
        chk("flush2 if_rdata kept", if_rdata, 32'h0A0A0A0A);
        chk("flush2 mem_req drop", 32'(mem_req), 32'h0);
        step();
        chk("flush2 idle", 32'(mem_req), 32'h0);

        // Starvation: d_req held with if_req high
        if_req = 1; if_addr = 32'h60;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        for (int g = 0; g <= N_DATA; g++) begin
            step();
            if (g == N_DATA)
                chk($sformatf("starve grant%0d fetch", g), 32'(mem_addr), 32'h18);
            else
                chk($sformatf("starve grant%0d data", g), 32'(mem_addr), 32'hC0);
            mem_ready = 1; mem_rdata = 32'(g + 1);
            step();
            mem_ready = 0;
            if (g == N_DATA) begin
                chk("starve if_valid", 32'(if_valid), 32'h1);
                chk("starve if_rdata", if_rdata, 32'(g + 1));
                if_req = 0; d_req = 0;
            end else begin
                chk($sformatf("starve d_ready%0d", g), 32'(d_ready), 32'h1);
                if (g == N_DATA - 1) begin
`ifndef ARB_STARVE_EN
                    d_req = 0;
`endif
                end
            end
        end
        step();

        // Reset in the middle of a data access
        d_req = 1; d_we = 0; d_addr = 32'h400;
        step();
        chk("rst mid grant", 32'(mem_addr), 32'h100);
        step();
        chk("rst mid still busy", 32'(mem_req), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        d_req = 0;
        chk_all_zero("rst mid");
        step();
        rst_n = 1'b1;
        if_req = 1; if_addr = 32'h70;
        step();
        chk("post rst grant", 32'(mem_req), 32'h1);
        chk("post rst addr", 32'(mem_addr), 32'h1C);
        mem_ready = 1; mem_rdata = 32'h12345678;
        step();
        mem_ready = 0; if_req = 0;
        chk("post rst if_valid", 32'(if_valid), 32'h1);
        chk("post rst if_rdata", if_rdata, 32'h12345678);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-ported 32-bit instruction/data memory between the fetch stage and the memory stage of the RISC-V pipeline. It serialises fetch and load/store requests onto the memory port with a ready handshake. It generates fetch-side backpressure so the hazard logic can derive Stall_F, and discards fetch responses that a taken branch or jump (PCSrc_E) has made stale.

## Interface
- STARVE_MAX, 4: maximum consecutive data grants while a fetch is waiting; range 1..15.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch byte address (PC_F); bits [1:0] ignored.
- if_flush  in  1  kill in-flight fetch (driven by PCSrc_E).
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction.
- if_busy  out  1  if_req && !if_valid (feeds Stall_F).
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  32  data byte address; bits [1:0] ignored.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle pulse: access complete, d_rdata valid for loads.
- d_rdata  out  32  load data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables (4'hF on fetch).
- mem_addr  out  30  word address = addr[31:2].
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory completes the access on this edge.
- mem_rdata  in  32  read data, valid when mem_ready is high.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. There is one outstanding transaction at most.
- IDLE: decision made on each rising edge.
  - d_req only goes to BUSY_D.
  - if_req only goes to BUSY_I.
  - Both set: data wins unless the starvation counter equals STARVE_MAX, in which case fetch wins.
  - No request stays in IDLE.
- On entering BUSY_x, mem_req/mem_we/mem_be/mem_addr/mem_wdata are registered from the winning requester and held constant until mem_ready is sampled high.
- BUSY_x with mem_ready high:
  - mem_req drops next cycle and the FSM returns to IDLE.
  - mem_rdata is captured into if_rdata or d_rdata.
  - The matching if_valid or d_ready pulses for exactly one cycle.
- Starvation counter, 4 bits:
  - Increments on each data grant while if_req is high.
  - Clears on every fetch grant and whenever if_req is low in IDLE.
  - Saturates at STARVE_MAX.
- Flush:
  - if_flush in BUSY_I sets the kill flag. The response completes on the memory port but if_valid is suppressed and if_rdata is not updated.
  - if_flush on the same edge as mem_ready in BUSY_I also kills.
  - The kill flag clears on return to IDLE.
  - if_flush in IDLE or BUSY_D has no effect.
- d_req is never killed; stores always complete.
- Store: d_rdata is unchanged, d_ready still pulses.
- Reset: FSM to IDLE; kill flag and counter cleared; all outputs zero, including if_rdata and d_rdata. An in-flight access is abandoned, and memory resets on the same rst_n.

## Timing
- Minimum latency: request high at edge N means mem_req high in cycle N+1. mem_ready in cycle N+1 means if_valid/d_ready high in cycle N+2.
- Back-to-back throughput: one access per 2 cycles minimum. IDLE lasts one cycle between transactions.
- if_busy is combinational from if_req and if_valid. All other outputs are registered.
- Requesters change address/data only after their valid/ready pulse. The fetch stage may change if_addr after if_flush.

## Configuration
- ARB_STARVE_EN defined: the starvation counter is active and fetch wins after STARVE_MAX consecutive data grants.
- ARB_STARVE_EN undefined: the counter is removed and data has strict priority whenever both requests are set. STARVE_MAX is ignored.

## Test plan
- Single fetch: if_req, if_addr=0x10, mem_ready one cycle after mem_req, mem_rdata=0x00500093 -> mem_addr=0x4, if_valid in cycle N+2, if_rdata=0x00500093.
- Contention: if_req and d_req (load 0x100) both high at the same edge -> data served first; then fetch; d_ready precedes if_valid by 2 cycles.
- Starvation, macro defined, STARVE_MAX=4: d_req held continuously with if_req high -> exactly 4 data grants, then a fetch grant. Without the macro, the fetch is never granted while d_req is high.
- Flush: if_flush asserted in BUSY_I before mem_ready (including the same edge as mem_ready) -> no if_valid, if_rdata unchanged, FSM back in IDLE after mem_ready.
- Store: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=4'b0011, d_ready pulses, d_rdata unchanged.
- Reset mid-op: rst_n low while in BUSY_D with mem_ready never asserted -> all outputs 0 immediately, and a fresh if_req after release is granted normally.
